road_phase_scheduler: RTL

- Timed phase sequencer for a main/secondary road intersection with pedestrian crossings.
- Derives a 1 s tick from the board clock (24 MHz nominal).
- Holds main-road green until there is demand from the secondary-road vehicle sensor or from a main-road crossing request.
- Serves latched pedestrian requests, drives both light sets and walk lamps, and exports the remaining phase time and a display enable to the 7-segment timer display.

---
 rtl/road_phase_scheduler_pkg.sv | 51 +++++
 rtl/road_phase_scheduler_if.sv | 32 +++
 rtl/road_phase_scheduler_tick_gen.sv | 35 +++
 rtl/road_phase_scheduler.sv | 118 +++++++++++
 4 files changed

// File: rtl/road_phase_scheduler_pkg.sv
// Shared definitions for the road phase scheduler: phase encoding, timer width
// and the lamp vector used by the top level and any display logic.
package road_pkg;

  localparam int TIMER_W = 8;

  localparam logic [2:0] MAIN_GREEN  = 3'd0;
  localparam logic [2:0] MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_1   = 3'd2;
  localparam logic [2:0] SEC_GREEN   = 3'd3;
  localparam logic [2:0] SEC_YELLOW  = 3'd4;
  localparam logic [2:0] ALL_RED_2   = 3'd5;

  // Per-road lamp set, ordered {green, yellow, red}
  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_GREEN  = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_RED    = 3'b001;

  typedef struct packed {
    lamp_t main_l;
    lamp_t sec_l;
  } lamp_vec_t;

  function automatic logic [2:0] next_phase(input logic [2:0] st);
    case (st)
      MAIN_GREEN:  return MAIN_YELLOW;
      MAIN_YELLOW: return ALL_RED_1;
      ALL_RED_1:   return SEC_GREEN;
      SEC_GREEN:   return SEC_YELLOW;
      SEC_YELLOW:  return ALL_RED_2;
      default:     return MAIN_GREEN;
    endcase
  endfunction

  function automatic lamp_vec_t decode_lamps(input logic [2:0] st);
    lamp_vec_t v;
    v.main_l = LAMP_RED;
    v.sec_l  = LAMP_RED;
    case (st)
      MAIN_GREEN:  v.main_l = LAMP_GREEN;
      MAIN_YELLOW: v.main_l = LAMP_YELLOW;
      SEC_GREEN:   v.sec_l  = LAMP_GREEN;
      SEC_YELLOW:  v.sec_l  = LAMP_YELLOW;
      default:     v = v;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/road_phase_scheduler_if.sv
// Sensor/request inputs and lamp/timer outputs of the road phase scheduler.
interface road_phase_scheduler_if import road_pkg::*; ();

  logic               sensor;
  logic               ped_req_main;
  logic               ped_req_sec;
  logic               green_main;
  logic               yellow_main;
  logic               red_main;
  logic               green_secondary;
  logic               yellow_secondary;
  logic               red_secondary;
  logic               walk_main;
  logic               walk_sec;
  logic [TIMER_W-1:0] timer;
  logic               en;

  modport master (
    output sensor, ped_req_main, ped_req_sec,
    input  green_main, yellow_main, red_main,
    input  green_secondary, yellow_secondary, red_secondary,
    input  walk_main, walk_sec, timer, en
  );

  modport slave (
    input  sensor, ped_req_main, ped_req_sec,
    output green_main, yellow_main, red_main,
    output green_secondary, yellow_secondary, red_secondary,
    output walk_main, walk_sec, timer, en
  );

endinterface

// File: rtl/road_phase_scheduler_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks, with a
// synchronous restart so each phase starts on a fresh tick boundary.
module tick_gen #(
  parameter int TICK_DIV = 24000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int             CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/road_phase_scheduler.sv
// Timed main/secondary intersection sequencer with latched pedestrian requests
// and a remaining-time output for the 7-segment display.
module road_phase_scheduler import road_pkg::*; #(
  parameter int TICK_DIV    = 24000000,
  parameter int T_MAIN_MIN  = 30,
  parameter int T_SEC_GREEN = 20,
  parameter int T_YELLOW    = 5,
  parameter int T_ALLRED    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  road_phase_scheduler_if.slave bus
);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pend_main_q, pend_main_d;
  logic               pend_sec_q, pend_sec_d;
  logic               walk_main_q, walk_main_d;
  logic               tick;
  logic               restart;
  logic               demand;
  logic               hold_zero;
  logic               entering_sg;
  logic               leaving_sg;
  logic               leaving_mg;
  lamp_vec_t          lamps;

  function automatic logic [TIMER_W-1:0] phase_len(input logic [2:0] st);
    case (st)
      MAIN_GREEN:              return TIMER_W'(T_MAIN_MIN);
      MAIN_YELLOW, SEC_YELLOW: return TIMER_W'(T_YELLOW);
      SEC_GREEN:               return TIMER_W'(T_SEC_GREEN);
      default:                 return TIMER_W'(T_ALLRED);
    endcase
  endfunction

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign demand    = bus.sensor | pend_main_q;
  // Main green has run its minimum time and is waiting for demand
  assign hold_zero = (state_q == MAIN_GREEN) && (timer_q == '0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (hold_zero) begin
      if (demand) begin
        state_d = MAIN_YELLOW;
      end
    end else if (tick) begin
      if (timer_q == TIMER_W'(1)) begin
        if ((state_q != MAIN_GREEN) || demand) begin
          state_d = next_phase(state_q);
        end else begin
          timer_d = '0;
        end
      end else begin
        timer_d = timer_q - TIMER_W'(1);
      end
    end
    if (state_d != state_q) begin
      timer_d = phase_len(state_d);
    end
  end

  assign restart     = (state_d != state_q) || hold_zero;
  assign entering_sg = (state_d == SEC_GREEN) && (state_q != SEC_GREEN);
  assign leaving_sg  = (state_q == SEC_GREEN) && (state_d != SEC_GREEN);
  assign leaving_mg  = (state_q == MAIN_GREEN) && (state_d != MAIN_GREEN);

  // A clear in the same cycle as a request drops that request
  assign pend_main_d = (pend_main_q | bus.ped_req_main) & ~entering_sg;
  assign pend_sec_d  = (pend_sec_q | bus.ped_req_sec) & ~leaving_mg;

  always_comb begin
    walk_main_d = walk_main_q;
    if (entering_sg) begin
      walk_main_d = pend_main_q;
    end else if (leaving_sg) begin
      walk_main_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAIN_GREEN;
      timer_q     <= TIMER_W'(T_MAIN_MIN);
      pend_main_q <= 1'b0;
      pend_sec_q  <= 1'b0;
      walk_main_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_main_q <= pend_main_d;
      pend_sec_q  <= pend_sec_d;
      walk_main_q <= walk_main_d;
    end
  end

  assign lamps                = decode_lamps(state_q);
  assign bus.green_main       = lamps.main_l[2];
  assign bus.yellow_main      = lamps.main_l[1];
  assign bus.red_main         = lamps.main_l[0];
  assign bus.green_secondary  = lamps.sec_l[2];
  assign bus.yellow_secondary = lamps.sec_l[1];
  assign bus.red_secondary    = lamps.sec_l[0];
  assign bus.walk_main        = walk_main_q;
  assign bus.walk_sec         = (state_q == MAIN_GREEN) & pend_sec_q;
  assign bus.timer            = timer_q;
  assign bus.en               = (timer_q != '0);

endmodule
